debounce_bank: RTL
==================

# debounce_bank

Parametrised multi-channel switch debouncer for front-panel buttons and switches. Each channel is synchronised, sampled on a shared prescaled tick and qualified by a consecutive-agreement counter. Each channel produces a clean level, single-cycle press and release strobes, and an optional auto-repeat strobe while held. The block sits between raw board inputs and the display/control logic and replaces the single-channel, rising-edge-only debouncer.

## Interface
Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- SAMPLE_DIV, 10: clocks per sample tick (>=1); set to clock_freq/2000 for a 500 us tick.
- STABLE_COUNT, 20: consecutive disagreeing ticks required to change a debounced level (>=1).
- REPEAT_DELAY, 0: held ticks before the first repeat strobe; 0 disables auto-repeat.
- REPEAT_RATE, 100: ticks between subsequent repeat strobes (>=1; ignored if REPEAT_DELAY=0).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- sw_in  in  CHANNELS  raw, asynchronous switch inputs; 1 = pressed.
- level  out  CHANNELS  debounced state per channel.
- press  out  CHANNELS  one-clock strobe when level goes 0->1.
- release  out  CHANNELS  one-clock strobe when level goes 1->0.
- rpt  out  CHANNELS  one-clock auto-repeat strobe while level=1.

## Operation
- Prescaler: shared counter div_cnt, width $clog2(SAMPLE_DIV+1), counts 0..SAMPLE_DIV-1 and wraps. tick=1 for exactly one clock when div_cnt==SAMPLE_DIV-1. With SAMPLE_DIV=1, tick=1 every clock.
- Synchroniser: per channel, two flops (s1<=sw_in, s2<=s1), reset to 0. Only s2 is used downstream.
- Stability counter stab_cnt, width $clog2(STABLE_COUNT+1), per channel, evaluated only on tick:
  - s2==level: stab_cnt<=0.
  - s2!=level and stab_cnt==STABLE_COUNT-1: level<=s2, stab_cnt<=0, and press or release <=1 for that clock.
  - Otherwise: stab_cnt<=stab_cnt+1.
- Any agreeing tick restarts qualification, so a glitch shorter than STABLE_COUNT ticks never reaches level.
- Auto-repeat (generated only if REPEAT_DELAY>0), per channel hold counter:
  - Cleared whenever level==0 and on the release clock.
  - While level==1, incremented on each tick.
  - rpt<=1 on the tick where the count reaches REPEAT_DELAY.
  - After that, rpt<=1 every REPEAT_RATE ticks: the counter reloads to REPEAT_DELAY-REPEAT_RATE, or the design uses an equivalent phase counter.
  - The hold counter never wraps to 0 while held.
- Channels are fully independent. Simultaneous events on different channels produce strobes in the same clock.
- press and rpt never assert in the same clock on one channel; the first rpt comes at the earliest REPEAT_DELAY ticks after press.

## Timing
- Reset (async assert, sync release): level, press, release, rpt, s1, s2, div_cnt, stab_cnt and hold counters all 0.
- Every output is registered; strobes are exactly one clk wide.
- Latency from a clean sw_in edge to level/strobe: 2 clocks of synchronisation, then the STABLE_COUNT-th tick whose s2 disagrees with level. Worst case is 2 + SAMPLE_DIV*STABLE_COUNT clocks.
- Strobes occur only in tick clocks. level changes in the same clock as its press/release strobe.
- Reset mid-qualification or mid-hold discards all progress. A switch held through reset produces press again STABLE_COUNT ticks after release of rst.
- sw_in toggling every tick never changes level, and no strobes occur.

## Test plan
- Reset: assert rst with all sw_in=1 -> all outputs 0 during rst. After release: level=1 with one press per channel, at tick STABLE_COUNT.
- Clean press, CHANNELS=4, SAMPLE_DIV=4, STABLE_COUNT=3: ch1 0->1 -> press[1] pulses once, level[1]=1. Latency is within 2+12 clocks; other channels stay quiet.
- Bounce: ch0 toggles on alternate ticks for 10 ticks, then holds 1 -> exactly one press[0], 3 ticks after the final toggle. No release.
- Glitch: ch2 high for 2 ticks, then low -> no level change, no strobes.
- Auto-repeat, REPEAT_DELAY=5, REPEAT_RATE=2: hold ch3 -> press, then rpt at held ticks 5, 7, 9, ... On release: one release strobe and no further rpt.
- Simultaneous: ch0 released while ch1 pressed in the same cycle -> release[0] and press[1] in the same clock. Async rst mid-hold clears rpt/level immediately.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel switch debouncer.
// One shared sample-tick prescaler drives an array of independent lanes. Each
// lane synchronises its raw input, qualifies level changes with a
// consecutive-disagreement counter, and emits press/release/auto-repeat strobes.

// ---------------------------------------------------------------------------
// debounce_lane: one channel. All outputs are registered.
// ---------------------------------------------------------------------------
module debounce_lane #(
  parameter int STABLE_COUNT = 20,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic sw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic rpt_o
);

  localparam int              SW        = $clog2(STABLE_COUNT + 1);
  localparam logic [SW-1:0]   STAB_LAST = SW'(STABLE_COUNT - 1);

  logic          s1_q, s2_q;
  logic [SW-1:0] stab_q, stab_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  // Two-flop synchroniser; only s2_q is trusted downstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sw_i;
      s2_q <= s1_q;
    end
  end

  // Qualification: any agreeing tick restarts the count, so only an unbroken
  // run of STABLE_COUNT disagreeing ticks moves the level.
  always_comb begin
    stab_d  = stab_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (tick_i) begin
      if (s2_q == level_q) begin
        stab_d = '0;
      end else if (stab_q == STAB_LAST) begin
        stab_d  = '0;
        level_d = s2_q;
        press_d = s2_q;
        rel_d   = ~s2_q;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end
  end

  // Level, stability counter and edge strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stab_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      stab_q  <= stab_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

  if (REPEAT_DELAY > 0) begin : g_rpt
    // hold_q counts held ticks up to REPEAT_DELAY and then parks there (never
    // wraps); from then on phase_q spaces the repeats REPEAT_RATE ticks apart.
    localparam int            HW        = $clog2(REPEAT_DELAY + 1);
    localparam int            RW        = $clog2(REPEAT_RATE + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] phase_q, phase_d;
    logic          rpt_q, rpt_d;

    // Hold/phase next state. Cleared while released and on the release tick,
    // so press and rpt can never coincide and a re-press starts from zero.
    always_comb begin
      hold_d  = hold_q;
      phase_d = phase_q;
      rpt_d   = 1'b0;
      if (!level_q || rel_d) begin
        hold_d  = '0;
        phase_d = '0;
      end else if (tick_i) begin
        if (hold_q == HOLD_LAST) begin
          hold_d = HOLD_MAX;
          rpt_d  = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end else if (phase_q == RATE_LAST) begin
          phase_d = '0;
          rpt_d   = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
    end

    // Auto-repeat state and strobe register.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        hold_q  <= '0;
        phase_q <= '0;
        rpt_q   <= 1'b0;
      end else begin
        hold_q  <= hold_d;
        phase_q <= phase_d;
        rpt_q   <= rpt_d;
      end
    end

    assign rpt_o = rpt_q;
  end else begin : g_no_rpt
    assign rpt_o = 1'b0;
  end

endmodule

// ---------------------------------------------------------------------------
// debounce_bank: shared prescaler plus CHANNELS lanes.
// ---------------------------------------------------------------------------
module debounce_bank #(
  parameter int CHANNELS     = 4,
  parameter int SAMPLE_DIV   = 10,
  parameter int STABLE_COUNT = 20,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] sw_in_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] rpt_o
);

  localparam int            DW       = $clog2(SAMPLE_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          tick;

  // tick is high for the single clock in which the prescaler sits at its
  // last count; with SAMPLE_DIV=1 that is every clock.
  assign tick      = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

  // Free-running sample prescaler shared by all lanes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) div_cnt_q <= '0;
    else       div_cnt_q <= div_cnt_d;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    debounce_lane #(
      .STABLE_COUNT(STABLE_COUNT),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .tick_i   (tick),
      .sw_i     (sw_in_i[g]),
      .level_o  (level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .rpt_o    (rpt_o[g])
    );
  end

endmodule
